board_io_debounce: RTL and testbench



---
 rtl/board_io_debounce.sv | 106 ++++++++++
 tb/tb_board_io_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : board_io_debounce
// Description : N-channel board input conditioner: synchronise, normalise
//               polarity, debounce; emits edge pulses, sticky flags and an IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module board_io_debounce #(
    parameter int                 NUM_CH        = 8,
    parameter int                 SYNC_STAGES   = 2,
    parameter int                 STABLE_CYCLES = 1000,
    parameter logic [NUM_CH-1:0]  INVERT        = '0,
    parameter logic [NUM_CH-1:0]  RESET_VAL     = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] pad_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] event_clr_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] event_o,
    output logic              irq_o
);

    localparam int                C_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STABLE_CYCLES - 1);
    // Chain resets to the raw level matching RESET_VAL so reset never looks like an edge.
    localparam logic [NUM_CH-1:0] C_SYNC_RST = RESET_VAL ^ INVERT;

    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] w_samp;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] r_event;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= C_SYNC_RST;
            end
        end else begin
            r_sync[0] <= pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_samp = r_sync[SYNC_STAGES-1] ^ INVERT;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [C_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               r_rise;
        logic               r_fall;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt   <= '0;
                r_level <= RESET_VAL[g];
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                // Enable low freezes the channel completely, including a pending count.
                if (en_i) begin
                    if (w_samp[g] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_cnt   <= '0;
                        r_level <= w_samp[g];
                        r_rise  <= w_samp[g];
                        r_fall  <= ~w_samp[g];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign w_level[g] = r_level;
        assign w_rise[g]  = r_rise;
        assign w_fall[g]  = r_fall;
    end

    // Flags latch the registered pulses, so a new event beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_event <= '0;
        end else begin
            r_event <= (w_rise | w_fall) | (r_event & ~event_clr_i);
        end
    end

    assign level_o = w_level;
    assign rise_o  = w_rise;
    assign fall_o  = w_fall;
    assign event_o = r_event;
    assign irq_o   = |r_event;

endmodule
`default_nettype wire

// File: tb/tb_board_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_debounce
// Description : Directed self-checking bench for board_io_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_debounce;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] pad_i;
    logic       en_i;
    logic [3:0] event_clr_i;
    logic [3:0] level_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic [3:0] event_o;
    logic       irq_o;

    int checks;
    int failures;

    board_io_debounce #(
        .NUM_CH       (4),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .INVERT       (4'b1000),
        .RESET_VAL    (4'b1000)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pad_i      (pad_i),
        .en_i       (en_i),
        .event_clr_i(event_clr_i),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .event_o    (event_o),
        .irq_o      (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        pad_i       = 4'b0000;
        en_i        = 1'b1;
        event_clr_i = 4'b0000;
        #23;
        checks++;
        if (level_o !== 4'b1000 || rise_o !== 4'b0 || fall_o !== 4'b0 || event_o !== 4'b0 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_in: level=%b rise=%b fall=%b event=%b irq=%b, required 1000/0000/0000/0000/0",
                     level_o, rise_o, fall_o, event_o, irq_o);
        end
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (level_o !== 4'b1000 || rise_o !== 4'b0 || fall_o !== 4'b0 || event_o !== 4'b0 || irq_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: level=%b rise=%b fall=%b event=%b irq=%b, required 1000/0000/0000/0000/0",
                         i, level_o, rise_o, fall_o, event_o, irq_o);
            end
        end
    endtask

    task automatic test_press();
        pad_i[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (level_o[0] !== (k >= 6) || rise_o[0] !== (k == 6) || event_o[0] !== (k >= 7) || irq_o !== (k >= 7)) begin
                failures++;
                $display("FAIL press edge%0d: level0=%b rise0=%b event0=%b irq=%b, required %b/%b/%b/%b",
                         k, level_o[0], rise_o[0], event_o[0], irq_o, k >= 6, k == 6, k >= 7, k >= 7);
            end
        end
    endtask

    task automatic test_glitch_bounce();
        int nrise;
        pad_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        pad_i[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (level_o !== 4'b1001 || rise_o !== 4'b0 || fall_o !== 4'b0) begin
                failures++;
                $display("FAIL glitch cyc%0d: level=%b rise=%b fall=%b, required 1001/0000/0000",
                         k, level_o, rise_o, fall_o);
            end
        end
        for (int i = 0; i < 12; i++) begin
            pad_i[2] = ((i / 2) % 2 == 0);
            step();
            checks++;
            if (level_o !== 4'b1001 || rise_o !== 4'b0 || fall_o !== 4'b0) begin
                failures++;
                $display("FAIL bounce cyc%0d: level=%b rise=%b fall=%b, required 1001/0000/0000",
                         i, level_o, rise_o, fall_o);
            end
        end
        pad_i[2] = 1'b1;
        nrise = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (rise_o[2] === 1'b1) nrise++;
            checks++;
            if (rise_o[2] !== (k == 6) || level_o[2] !== (k >= 6)) begin
                failures++;
                $display("FAIL bounce_final edge%0d: rise2=%b level2=%b, required %b/%b",
                         k, rise_o[2], level_o[2], k == 6, k >= 6);
            end
        end
        checks++;
        if (nrise != 1) begin
            failures++;
            $display("FAIL bounce_count: rise2 pulses=%0d, required 1", nrise);
        end
        event_clr_i = 4'b0111;
        step();
        event_clr_i = 4'b0000;
        checks++;
        if (event_o !== 4'b0000 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_all: event=%b irq=%b, required 0000/0", event_o, irq_o);
        end
    endtask

    task automatic test_set_clear_collision();
        pad_i[0] = 1'b0;
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (fall_o[0] !== 1'b1 || level_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL collide_fall: fall0=%b level0=%b, required 1/0", fall_o[0], level_o[0]);
        end
        event_clr_i[0] = 1'b1;
        step();
        checks++;
        if (event_o[0] !== 1'b1 || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL collide_set_wins: event0=%b irq=%b, required 1/1", event_o[0], irq_o);
        end
        step();
        event_clr_i[0] = 1'b0;
        checks++;
        if (event_o[0] !== 1'b0 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL collide_clear: event0=%b irq=%b, required 0/0", event_o[0], irq_o);
        end
    endtask

    task automatic test_invert_enable();
        // ch3 is active-low; driving the raw pad high releases it (level 1 -> 0).
        pad_i[3] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        en_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (level_o[3] !== 1'b1 || fall_o[3] !== 1'b0) begin
                failures++;
                $display("FAIL freeze cyc%0d: level3=%b fall3=%b, required 1/0", k, level_o[3], fall_o[3]);
            end
        end
        en_i = 1'b1;
        step();
        checks++;
        if (fall_o[3] !== 1'b0 || level_o[3] !== 1'b1) begin
            failures++;
            $display("FAIL resume_e1: fall3=%b level3=%b, required 0/1", fall_o[3], level_o[3]);
        end
        step();
        checks++;
        if (fall_o[3] !== 1'b1 || level_o[3] !== 1'b0 || rise_o[3] !== 1'b0) begin
            failures++;
            $display("FAIL resume_e2: fall3=%b level3=%b rise3=%b, required 1/0/0", fall_o[3], level_o[3], rise_o[3]);
        end
        step();
        checks++;
        if (event_o !== 4'b1000 || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL resume_event: event=%b irq=%b, required 1000/1", event_o, irq_o);
        end
    endtask

    task automatic test_reset_mid_count();
        pad_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst_ni = 1'b0;
        #2;
        checks++;
        if (level_o !== 4'b1000 || rise_o !== 4'b0 || fall_o !== 4'b0 || event_o !== 4'b0 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: level=%b rise=%b fall=%b event=%b irq=%b, required 1000/0000/0000/0000/0",
                     level_o, rise_o, fall_o, event_o, irq_o);
        end
        step();
        rst_ni = 1'b1;
        // pads now 1101: ch0, ch2 differ from reset level (rise); ch3 raw high means released (fall).
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (rise_o !== ((k == 6) ? 4'b0101 : 4'b0000) || fall_o !== ((k == 6) ? 4'b1000 : 4'b0000) ||
                level_o !== ((k >= 6) ? 4'b0101 : 4'b1000) || event_o !== ((k >= 7) ? 4'b1101 : 4'b0000)) begin
                failures++;
                $display("FAIL midreset_edge%0d: rise=%b fall=%b level=%b event=%b", k, rise_o, fall_o, level_o, event_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_press();
        test_glitch_bounce();
        test_set_clear_collision();
        test_invert_enable();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
